// File: rtl/exc_ctrl_pkg.sv
// exc_ctrl_pkg: exception bit indices, type/state encodings and ExcCode mapping
package exc_ctrl_pkg;
  localparam int E_INT = 0, E_ADEL_I = 1, E_ADEL_D = 2, E_ADES = 3;
  localparam int E_SYS = 4, E_BP = 5, E_RI = 6, E_OV = 7;
  localparam int ST_IE = 0, ST_EXL = 1, ST_ERL = 2, ST_BEV = 22;
  localparam logic [4:0] C_INT = 5'd0, C_ADEL = 5'd4, C_ADES = 5'd5, C_SYS = 5'd8;
  localparam logic [4:0] C_BP = 5'd9, C_RI = 5'd10, C_OV = 5'd12;
  typedef enum logic [3:0] {
    T_NONE, T_INT, T_ADEL_I, T_ADEL_D, T_ADES, T_SYS, T_BP, T_RI, T_OV, T_ERET
  } exc_type_t;
  typedef enum logic [1:0] {S_IDLE, S_SAVE, S_FLUSH, S_DRAIN} state_t;
  function automatic logic [4:0] exc_code(exc_type_t t);
    return (t == T_ADEL_I || t == T_ADEL_D) ? C_ADEL :
           t == T_ADES ? C_ADES : t == T_SYS ? C_SYS : t == T_BP ? C_BP :
           t == T_RI ? C_RI : t == T_OV ? C_OV : C_INT;
  endfunction
endpackage

// File: rtl/exc_ctrl_intr_sync.sv
// exc_intr_sync: multi-stage synchroniser for the six hardware interrupt lines
module exc_intr_sync #(
  parameter int STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] d,
  output logic [5:0] q
);
  logic [STAGES-1:0][5:0] r;
  always_ff @(posedge clk or posedge rst)
    if (rst) r <= '0;
    else r <= {r[STAGES-2:0], d};
  assign q = r[STAGES-1];
endmodule

// File: rtl/exc_ctrl.sv
// exc_ctrl: commit-point exception controller with CP0 save handshake, flush and drain stall
module exc_ctrl
  import exc_ctrl_pkg::*;
#(
  parameter int                NUM_EXC     = 9,
  parameter int                ADDR_W      = 32,
  parameter int                SYNC_STAGES = 2,
  parameter int                DRAIN_CYC   = 3,
  parameter logic [ADDR_W-1:0] VEC_BEV     = 32'hBFC00380,
  parameter logic [ADDR_W-1:0] VEC_NORM    = 32'h80000180
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              exc_valid_i,
  input  logic [ADDR_W-1:0] exc_pc_i,
  input  logic              exc_in_ds_i,
  input  logic              exc_mem_en_i,
  input  logic [ADDR_W-1:0] exc_m_addr_i,
  input  logic [NUM_EXC-1:0] exc_excs_i,
  input  logic [5:0]        exc_intr_i,
  input  logic [31:0]       exc_Status_i,
  input  logic [31:0]       exc_Cause_i,
  input  logic [31:0]       exc_EPC_i,
  input  logic [31:0]       exc_ErrorEPC_i,
  input  logic              cp0_ack_i,
  output logic              exc_save_o,
  output exc_type_t         exc_type_o,
  output logic [4:0]        exc_code_o,
  output logic [ADDR_W-1:0] exc_epc_o,
  output logic              exc_bd_o,
  output logic [ADDR_W-1:0] exc_baddr_o,
  output logic              flush_o,
  output logic [ADDR_W-1:0] flush_pc_o,
  output logic              stall_o
);
  localparam int IW = $clog2(NUM_EXC);
  localparam int CW = DRAIN_CYC > 1 ? $clog2(DRAIN_CYC) : 1;
  logic [5:0] intr_sync;
  logic pend, hit, unused;
  logic [NUM_EXC-1:0] excs;
  logic [IW-1:0] sel;
  exc_type_t nxt_type;
  logic [ADDR_W-1:0] nxt_epc, nxt_baddr, nxt_target;
  state_t state;
  logic [CW-1:0] cnt;
  exc_intr_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (exc_intr_i),
    .q  (intr_sync)
  );
  assign pend = |({intr_sync, exc_Cause_i[9:8]} & exc_Status_i[15:8]) & exc_Status_i[ST_IE]
              & ~exc_Status_i[ST_EXL] & ~exc_Status_i[ST_ERL];
  assign excs = {exc_excs_i[NUM_EXC-1:1], pend & ~exc_mem_en_i};
  assign hit  = |excs;
  always_comb begin
    sel = '0;
    for (int i = NUM_EXC - 1; i >= 0; i--) if (excs[i]) sel = IW'(i);
  end
  assign nxt_type   = sel == IW'(NUM_EXC - 1) ? T_ERET : exc_type_t'(4'(sel) + 4'd1);
  assign nxt_epc    = exc_in_ds_i ? exc_pc_i - ADDR_W'(4) : exc_pc_i;
  assign nxt_baddr  = nxt_type == T_ADEL_I ? exc_pc_i :
                      (nxt_type == T_ADEL_D || nxt_type == T_ADES) ? exc_m_addr_i : '0;
  assign nxt_target = nxt_type == T_ERET ?
                      (exc_Status_i[ST_ERL] ? ADDR_W'(exc_ErrorEPC_i) : ADDR_W'(exc_EPC_i)) :
                      exc_Status_i[ST_BEV] ? VEC_BEV : VEC_NORM;
  assign unused = ^{exc_excs_i[0], exc_Status_i, exc_Cause_i, exc_EPC_i, exc_ErrorEPC_i};
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      exc_save_o  <= 1'b0;
      exc_type_o  <= T_NONE;
      exc_code_o  <= '0;
      exc_epc_o   <= '0;
      exc_bd_o    <= 1'b0;
      exc_baddr_o <= '0;
      flush_o     <= 1'b0;
      flush_pc_o  <= '0;
      stall_o     <= 1'b0;
    end else
      case (state)
        S_IDLE: if (exc_valid_i && hit) begin
          state       <= nxt_type == T_ERET ? S_FLUSH : S_SAVE;
          exc_save_o  <= nxt_type != T_ERET;
          flush_o     <= nxt_type == T_ERET;
          stall_o     <= 1'b1;
          exc_type_o  <= nxt_type;
          exc_code_o  <= exc_code(nxt_type);
          exc_epc_o   <= nxt_epc;
          exc_bd_o    <= exc_in_ds_i;
          exc_baddr_o <= nxt_baddr;
          flush_pc_o  <= nxt_target;
        end
        S_SAVE: if (cp0_ack_i) begin
          state      <= S_FLUSH;
          exc_save_o <= 1'b0;
          flush_o    <= 1'b1;
        end
        S_FLUSH: begin
          state   <= S_DRAIN;
          flush_o <= 1'b0;
          cnt     <= CW'(DRAIN_CYC - 1);
        end
        default: if (cnt == '0) begin
          state   <= S_IDLE;
          stall_o <= 1'b0;
        end else cnt <= cnt - CW'(1);
      endcase
endmodule

// File: tb/tb_exc_ctrl.sv
// tb_exc_ctrl: directed scenario checks for exc_ctrl
module tb_exc_ctrl;
  import exc_ctrl_pkg::*;
  logic clk = 0, rst = 1;
  logic valid, in_ds, mem_en, ack;
  logic [31:0] pc, m_addr, status, cause, epc_in, errepc;
  logic [8:0] excs;
  logic [5:0] intr;
  logic save, bd, flush, stall;
  exc_type_t typ;
  logic [4:0] code;
  logic [31:0] epc, baddr, fpc;
  int total = 0, bad = 0;
  exc_ctrl dut (
    .clk(clk), .rst(rst), .exc_valid_i(valid), .exc_pc_i(pc), .exc_in_ds_i(in_ds),
    .exc_mem_en_i(mem_en), .exc_m_addr_i(m_addr), .exc_excs_i(excs), .exc_intr_i(intr),
    .exc_Status_i(status), .exc_Cause_i(cause), .exc_EPC_i(epc_in), .exc_ErrorEPC_i(errepc),
    .cp0_ack_i(ack), .exc_save_o(save), .exc_type_o(typ), .exc_code_o(code), .exc_epc_o(epc),
    .exc_bd_o(bd), .exc_baddr_o(baddr), .flush_o(flush), .flush_pc_o(fpc), .stall_o(stall)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic idle_inputs;
    valid = 0; in_ds = 0; mem_en = 0; ack = 0; pc = 0; m_addr = 0; excs = 0; intr = 0;
    status = 0; cause = 0; epc_in = 0; errepc = 0;
  endtask
  task automatic test_reset;
    idle_inputs();
    rst = 1;
    tick(); tick();
    total++;
    if ({save, typ, code, epc, bd, baddr, flush, fpc, stall} !== '0) begin
      bad++; $display("FAIL reset outputs got=%h required=0", {save, typ, code, epc, bd, baddr, flush, fpc, stall});
    end
    rst = 0;
    tick();
  endtask
  task automatic test_ri;
    valid = 1; pc = 32'hBFC00010; excs = 9'h040; status = 32'h0040_0000;
    tick();
    valid = 0; excs = 0;
    total++;
    if ({save, stall, typ, code, epc} !== {1'b1, 1'b1, T_RI, 5'd10, 32'hBFC00010}) begin
      bad++; $display("FAIL ri_save got=%b%b %0d %0d %h required=11 7 10 bfc00010", save, stall, typ, code, epc);
    end
    tick();
    total++;
    if (save !== 1'b1) begin bad++; $display("FAIL ri_save2 got=%b required=1", save); end
    tick();
    total++;
    if (save !== 1'b1 || flush !== 1'b0) begin bad++; $display("FAIL ri_save3 got=%b%b required=10", save, flush); end
    ack = 1;
    tick();
    ack = 0;
    total++;
    if ({save, flush, stall, fpc} !== {3'b011, 32'hBFC00380}) begin
      bad++; $display("FAIL ri_flush got=%b%b%b %h required=011 bfc00380", save, flush, stall, fpc);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (stall !== 1'b1 || flush !== 1'b0) begin bad++; $display("FAIL ri_drain%0d got=%b%b required=10", i, stall, flush); end
    end
    tick();
    total++;
    if (stall !== 1'b0) begin bad++; $display("FAIL ri_drain_end got=%b required=0", stall); end
  endtask
  task automatic test_ades_ov;
    valid = 1; pc = 32'h80000100; in_ds = 1; m_addr = 32'h80001003; excs = 9'h088; status = 0;
    tick();
    valid = 0; excs = 0; in_ds = 0; ack = 1;
    total++;
    if ({typ, code, baddr, epc, bd} !== {T_ADES, 5'd5, 32'h80001003, 32'h800000FC, 1'b1}) begin
      bad++; $display("FAIL ades_ov got=%0d %0d %h %h %b required=4 5 80001003 800000fc 1", typ, code, baddr, epc, bd);
    end
    tick();
    ack = 0;
    total++;
    if ({flush, fpc} !== {1'b1, 32'h80000180}) begin
      bad++; $display("FAIL ades_flush got=%b %h required=1 80000180", flush, fpc);
    end
    for (int i = 0; i < 8 && stall; i++) tick();
    total++;
    if (stall !== 1'b0) begin bad++; $display("FAIL ades_idle got=%b required=0", stall); end
  endtask
  task automatic test_adel;
    valid = 1; pc = 32'h00000401; m_addr = 32'h999; excs = 9'h006;
    tick();
    valid = 0; excs = 0; ack = 1;
    total++;
    if ({typ, code, baddr} !== {T_ADEL_I, 5'd4, 32'h401}) begin
      bad++; $display("FAIL adel got=%0d %0d %h required=2 4 401", typ, code, baddr);
    end
    tick();
    ack = 0;
    for (int i = 0; i < 8 && stall; i++) tick();
    total++;
    if (stall !== 1'b0) begin bad++; $display("FAIL adel_idle got=%b required=0", stall); end
  endtask
  task automatic test_intr;
    status = 32'h0000_1001; pc = 32'h80000040; valid = 1; mem_en = 1; intr = 6'h04;
    for (int i = 0; i < 4; i++) tick();
    total++;
    if (save !== 1'b0) begin bad++; $display("FAIL intr_holdoff got=%b required=0", save); end
    mem_en = 0;
    tick();
    valid = 0;
    total++;
    if ({save, typ, code, epc} !== {1'b1, T_INT, 5'd0, 32'h80000040}) begin
      bad++; $display("FAIL intr_take got=%b %0d %0d %h required=1 1 0 80000040", save, typ, code, epc);
    end
    ack = 1; intr = 0;
    tick();
    ack = 0;
    for (int i = 0; i < 8 && stall; i++) tick();
    tick(); tick();
    valid = 1; intr = 6'h04;
    tick(); tick();
    total++;
    if (save !== 1'b0) begin bad++; $display("FAIL intr_sync_early got=%b required=0", save); end
    tick();
    valid = 0;
    total++;
    if (save !== 1'b1) begin bad++; $display("FAIL intr_sync_latency got=%b required=1", save); end
    ack = 1;
    tick();
    ack = 0;
    for (int i = 0; i < 8 && stall; i++) tick();
    status = 32'h0000_1003; valid = 1;
    for (int i = 0; i < 4; i++) tick();
    total++;
    if (save !== 1'b0 || stall !== 1'b0) begin bad++; $display("FAIL intr_exl_mask got=%b%b required=00", save, stall); end
    valid = 0; intr = 0; status = 0;
    tick(); tick(); tick();
  endtask
  task automatic test_eret;
    status = 32'h0000_0004; errepc = 32'h1234; epc_in = 32'h5555; valid = 1; excs = 9'h100;
    tick();
    valid = 0; excs = 0;
    total++;
    if ({save, flush, stall, typ, fpc} !== {3'b011, T_ERET, 32'h1234}) begin
      bad++; $display("FAIL eret got=%b%b%b %0d %h required=011 9 1234", save, flush, stall, typ, fpc);
    end
    for (int i = 0; i < 8 && stall; i++) tick();
    total++;
    if (stall !== 1'b0 || save !== 1'b0) begin bad++; $display("FAIL eret_idle got=%b%b required=00", stall, save); end
    status = 0;
  endtask
  task automatic test_rst_mid;
    valid = 1; pc = 32'h100; excs = 9'h040;
    tick();
    valid = 0; excs = 0;
    rst = 1;
    #1;
    total++;
    if ({save, typ, code, epc, bd, baddr, flush, fpc, stall} !== '0) begin
      bad++; $display("FAIL rst_mid got=%h required=0", {save, typ, code, epc, bd, baddr, flush, fpc, stall});
    end
    tick();
    rst = 0; ack = 1;
    tick();
    ack = 0;
    total++;
    if ({save, flush, stall} !== 3'b000) begin bad++; $display("FAIL rst_noflush got=%b required=000", {save, flush, stall}); end
  endtask
  task automatic test_back_to_back;
    valid = 1; pc = 32'h0; in_ds = 1; excs = 9'h010; ack = 1;
    tick();
    valid = 0; excs = 0; in_ds = 0;
    total++;
    if ({code, epc, bd, baddr} !== {5'd8, 32'hFFFFFFFC, 1'b1, 32'h0}) begin
      bad++; $display("FAIL sys_wrap got=%0d %h %b %h required=8 fffffffc 1 0", code, epc, bd, baddr);
    end
    tick();
    ack = 0;
    tick();
    valid = 1; excs = 9'h020;
    tick();
    total++;
    if (save !== 1'b0 || stall !== 1'b1) begin bad++; $display("FAIL drain_ignore1 got=%b%b required=01", save, stall); end
    tick();
    valid = 0; excs = 0;
    total++;
    if (save !== 1'b0 || code !== 5'd8) begin bad++; $display("FAIL drain_ignore2 got=%b %0d required=0 8", save, code); end
    tick();
    total++;
    if ({save, stall, code} !== {2'b00, 5'd8}) begin bad++; $display("FAIL drain_ignore_end got=%b%b %0d required=00 8", save, stall, code); end
  endtask
  initial begin
    test_reset();
    test_ri();
    test_ades_ov();
    test_adel();
    test_intr();
    test_eret();
    test_rst_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
